nic_core: RTL and testbench

CPU-facing network interface controller sitting between the processor-side driver (addr/d_in/nicEn/nicEnWR) and the mesh router's local port. It holds a parameterised output FIFO for CPU-written packets and a single-entry input buffer for router-delivered packets, exposes both plus status words through a 2-bit register map, and runs a valid/ready handshake on each router channel.

---
 rtl/nic_core.sv | 122 ++++++++++++
 tb/tb_nic_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nic_core.sv
// CPU-facing NIC: output FIFO toward the router's local port, a single-entry input buffer
// from the router, and a 2-bit register map. Optional drop counter under NIC_DROP_CNT_EN.
module nic_core #(
  parameter int PACKET_WIDTH = 64,
  parameter int OBUF_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]             r_wr_ptr;
  logic [PW:0]             r_rd_ptr;
  logic [PACKET_WIDTH-1:0] r_mem [OBUF_DEPTH];
  logic [PACKET_WIDTH-1:0] r_ibuf;
  logic                    r_ibuf_vld;

  logic                    w_full;
  logic                    w_empty;
  logic [PW:0]             w_count;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_push;
  logic                    w_pop;
  logic [PACKET_WIDTH-1:0] w_ostat;

  // Full/empty come from pre-edge pointers, so a push while full is dropped even if a pop lands too.
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_wr   = nicEn & nicEnWR;
  assign w_rd   = nicEn & ~nicEnWR;
  assign w_push = w_wr && (addr == 2'b10) && !w_full;
  assign w_pop  = !w_empty && net_ro;

  assign net_so = !w_empty;
  assign net_do = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];
  assign net_ri = !r_ibuf_vld;

`ifdef NIC_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = w_wr && (addr == 2'b10) && w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_wr && (addr == 2'b11)) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    w_ostat       = '0;
    w_ostat[0]    = w_full;
    w_ostat[1]    = w_empty;
    w_ostat[15:8] = 8'(w_count);
`ifdef NIC_DROP_CNT_EN
    w_ostat[31:16] = r_drop_cnt;
`endif
  end

  // Output FIFO pointers and storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= d_in;
  end

  // Input buffer data is only visible through r_ibuf_vld, so it needs no reset
  always_ff @(posedge clk) begin
    if (net_si && !r_ibuf_vld) r_ibuf <= net_di;
  end

  // CPU read port and input-buffer occupancy; capture and CPU clear never coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out      <= '0;
      r_ibuf_vld <= 1'b0;
    end else begin
      if (net_si && !r_ibuf_vld) r_ibuf_vld <= 1'b1;
      if (w_rd) begin
        case (addr)
          2'b00: begin
            d_out <= r_ibuf_vld ? r_ibuf : '0;
            if (r_ibuf_vld) r_ibuf_vld <= 1'b0;
          end
          2'b01:   d_out <= {{(PACKET_WIDTH-1){1'b0}}, r_ibuf_vld};
          2'b10:   d_out <= '0;
          default: d_out <= w_ostat;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nic_core.sv
// Directed bench for nic_core: FIFO fill/drain/drop, input buffer handshake, register map, async reset.
module tb_nic_core;

  localparam int PW = 64;
`ifdef NIC_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [PW-1:0] d_in;
  logic [PW-1:0] d_out;
  logic          nicEn;
  logic          nicEnWR;
  logic          net_so;
  logic          net_ro;
  logic [PW-1:0] net_do;
  logic          net_si;
  logic          net_ri;
  logic [PW-1:0] net_di;

  int            n_vec = 0;
  int            n_err = 0;
  logic [PW-1:0] rd;
  logic [PW-1:0] pkt [4];

  always #5 clk = ~clk;

  nic_core #(.PACKET_WIDTH(PW), .OBUF_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .d_in    (d_in),
    .d_out   (d_out),
    .nicEn   (nicEn),
    .nicEnWR (nicEnWR),
    .net_so  (net_so),
    .net_ro  (net_ro),
    .net_do  (net_do),
    .net_si  (net_si),
    .net_ri  (net_ri),
    .net_di  (net_di)
  );

  task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ostat(input bit full, input bit empty, input int cnt, input int drops);
    logic [PW-1:0] s;
    s       = '0;
    s[0]    = full;
    s[1]    = empty;
    s[15:8] = 8'(cnt);
    if (DROP_EN) s[31:16] = 16'(drops);
    return s;
  endfunction

  task automatic cpu_read(input logic [1:0] a, output logic [PW-1:0] v);
    @(negedge clk);
    nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
    @(negedge clk);
    nicEn = 1'b0;
    v = d_out;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [PW-1:0] v);
    @(negedge clk);
    nicEn = 1'b1; nicEnWR = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    nicEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWR = 1'b0;
    net_ro = 1'b0; net_si = 1'b0; net_di = '0;
    for (int i = 0; i < 4; i++) pkt[i] = {32'hC0DE_0000 + 32'(i), 32'h0000_00F0 + 32'(i)};

    #12;
    check_val("rst_dout", d_out, '0);
    check_val("rst_so", {63'd0, net_so}, 64'd0);
    check_val("rst_do", net_do, '0);
    check_val("rst_ri", {63'd0, net_ri}, 64'd1);
    @(negedge clk);
    reset = 1'b1;

    // fill with router stalled, fifth write dropped
    cpu_write(2'b10, 64'hDEADBEEF_DEADBEEF);
    check_val("so_after_push", {63'd0, net_so}, 64'd1);
    check_val("do_head", net_do, 64'hDEADBEEF_DEADBEEF);
    for (int i = 0; i < 3; i++) cpu_write(2'b10, 64'hDEADBEEF_DEADBEEF);
    cpu_write(2'b10, 64'h1);
    cpu_read(2'b11, rd);
    check_val("stat_full4", rd, ostat(1, 0, 4, 1));

    // drain one per cycle
    @(negedge clk);
    net_ro = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_do", net_do, 64'hDEADBEEF_DEADBEEF);
      check_val("drain_so", {63'd0, net_so}, 64'd1);
      @(negedge clk);
    end
    check_val("drained_so", {63'd0, net_so}, 64'd0);
    check_val("drained_do", net_do, '0);
    net_ro = 1'b0;
    cpu_read(2'b11, rd);
    check_val("stat_empty", rd, ostat(0, 1, 0, 1));

    // full FIFO, push and pop in the same cycle: push dropped, pop happens
    for (int i = 0; i < 4; i++) cpu_write(2'b10, pkt[i]);
    cpu_read(2'b11, rd);
    check_val("stat_full_b", rd, ostat(1, 0, 4, 1));
    @(negedge clk);
    net_ro = 1'b1; nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'b10; d_in = 64'hA5;
    check_val("head_p0", net_do, pkt[0]);
    @(negedge clk);
    net_ro = 1'b0; nicEn = 1'b0;
    check_val("head_p1", net_do, pkt[1]);
    cpu_read(2'b11, rd);
    check_val("stat_cnt3", rd, ostat(0, 0, 3, 2));
    @(negedge clk);
    net_ro = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check_val("order_do", net_do, pkt[i]);
      @(negedge clk);
    end
    check_val("a5_dropped_so", {63'd0, net_so}, 64'd0);
    net_ro = 1'b0;
    cpu_read(2'b11, rd);
    check_val("stat_empty_b", rd, ostat(0, 1, 0, 2));

    // input buffer handshake
    @(negedge clk);
    net_si = 1'b1; net_di = 64'h1234;
    check_val("ri_idle", {63'd0, net_ri}, 64'd1);
    @(negedge clk);
    check_val("ri_captured", {63'd0, net_ri}, 64'd0);
    net_di = 64'h5678;
    @(negedge clk);
    check_val("ri_hold", {63'd0, net_ri}, 64'd0);
    cpu_read(2'b00, rd);
    check_val("ibuf_first", rd, 64'h1234);
    check_val("ri_after_read", {63'd0, net_ri}, 64'd1);
    @(negedge clk);
    check_val("ri_second", {63'd0, net_ri}, 64'd0);
    net_si = 1'b0;
    cpu_read(2'b01, rd);
    check_val("istat_full", rd, 64'd1);
    cpu_read(2'b00, rd);
    check_val("ibuf_second", rd, 64'h5678);
    cpu_read(2'b01, rd);
    check_val("istat_empty", rd, 64'd0);

    // register map corners
    cpu_read(2'b11, rd);
    check_val("stat_nz", rd, ostat(0, 1, 0, 2));
    @(negedge clk);
    @(negedge clk);
    check_val("dout_hold", d_out, ostat(0, 1, 0, 2));
    cpu_read(2'b00, rd);
    check_val("ibuf_empty_rd", rd, 64'd0);
    cpu_read(2'b11, rd);
    cpu_read(2'b10, rd);
    check_val("rd_obuf_zero", rd, 64'd0);
    cpu_write(2'b00, 64'hFFFF_FFFF);
    cpu_write(2'b01, 64'hFFFF_FFFF);
    check_val("ri_after_wr00", {63'd0, net_ri}, 64'd1);
    cpu_read(2'b01, rd);
    check_val("istat_after_wr", rd, 64'd0);
    cpu_read(2'b11, rd);
    check_val("stat_after_wr", rd, ostat(0, 1, 0, 2));
    cpu_write(2'b11, 64'h0);
    cpu_read(2'b11, rd);
    check_val("stat_after_clr", rd, ostat(0, 1, 0, 0));

    // push and pop together on a partly filled FIFO
    cpu_write(2'b10, pkt[0]);
    @(negedge clk);
    net_ro = 1'b1; nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'b10; d_in = pkt[1];
    @(negedge clk);
    net_ro = 1'b0; nicEn = 1'b0;
    check_val("pushpop_head", net_do, pkt[1]);
    cpu_read(2'b11, rd);
    check_val("pushpop_cnt", rd, ostat(0, 0, 1, 0));

    // asynchronous reset mid-cycle with data buffered
    cpu_write(2'b10, pkt[2]);
    @(negedge clk);
    net_si = 1'b1; net_di = 64'h9ABC;
    @(negedge clk);
    net_si = 1'b0;
    check_val("pre_rst_ri", {63'd0, net_ri}, 64'd0);
    cpu_read(2'b01, rd);
    check_val("pre_rst_dout", rd, 64'd1);
    check_val("pre_rst_so", {63'd0, net_so}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_dout", d_out, '0);
    check_val("arst_so", {63'd0, net_so}, 64'd0);
    check_val("arst_do", net_do, '0);
    check_val("arst_ri", {63'd0, net_ri}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    cpu_read(2'b11, rd);
    check_val("post_rst_stat", rd, ostat(0, 1, 0, 0));
    cpu_read(2'b01, rd);
    check_val("post_rst_istat", rd, 64'd0);
    cpu_read(2'b00, rd);
    check_val("post_rst_ibuf", rd, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
